// File: rtl/clock_gen_pkg.sv
// Shared types and helpers for the synchronous clock strobe generator.
package clock_gen_pkg;

    localparam int DIV_W_DEF = 16;

    typedef logic [DIV_W_DEF-1:0] div_t;

    // Channel select width; a single channel still gets a 1-bit select.
    function automatic int ch_idx_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/clock_div_channel.sv
// One programmable divider channel: period counter, active divide ratio and
// a single-entry pending ratio that is swapped in only at a period boundary.
module clock_div_channel
    import clock_gen_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             i_acc,
    input  logic [DIV_W-1:0] i_acc_div,
    output logic             o_pend,
    output logic             o_stb,
    output logic             o_sq
);

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_phase;
    logic [DIV_W-1:0] r_pend_div;
    logic             r_pend;
    logic             r_stb;
    logic             r_sq;

    logic [DIV_W-1:0] w_phase_inc;
    logic [DIV_W-1:0] w_next_div;
    logic             w_wrap;

    // An OFF channel is treated as permanently at its boundary, so a pending
    // ratio loads on the very next enabled cycle.
    always_comb begin
        w_phase_inc = r_phase + DIV_W'(1);
        w_wrap      = (r_div == '0) || (r_phase == r_div - DIV_W'(1));
        w_next_div  = r_pend ? r_pend_div : r_div;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_div      <= '0;
            r_phase    <= '0;
            r_pend_div <= '0;
            r_pend     <= 1'b0;
            r_stb      <= 1'b0;
            r_sq       <= 1'b0;
        end else begin
            if (en) begin
                if (w_wrap) begin
                    r_div   <= w_next_div;
                    r_phase <= '0;
                    r_pend  <= 1'b0;
                    r_stb   <= (w_next_div != '0);
                    r_sq    <= ((w_next_div >> 1) != '0);
                end else begin
                    r_phase <= w_phase_inc;
                    r_stb   <= 1'b0;
                    r_sq    <= (w_phase_inc < (r_div >> 1));
                end
            end else begin
                r_stb <= 1'b0;
            end
            // Accept only happens while nothing is pending, so it never races a load.
            if (i_acc) begin
                r_pend     <= 1'b1;
                r_pend_div <= i_acc_div;
            end
        end
    end

    assign o_pend = r_pend;
    assign o_stb  = r_stb;
    assign o_sq   = r_sq;

endmodule

// File: rtl/clock_strobe_gen.sv
// Single-domain strobe generator: binary taps from a free-running counter plus
// NUM_CH programmable divider channels written through a valid/ready port.
module clock_strobe_gen
    import clock_gen_pkg::*;
#(
    parameter  int TAPS   = 8,
    parameter  int NUM_CH = 2,
    parameter  int DIV_W  = DIV_W_DEF,
    localparam int CH_W   = ch_idx_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    output logic [TAPS-1:0]   tap_out,
    output logic [TAPS-1:0]   tap_stb,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic [NUM_CH-1:0] ch_stb,
    output logic [NUM_CH-1:0] ch_sq
);

    logic [TAPS-1:0]   r_cnt;
    logic [TAPS-1:0]   r_tap_stb;
    logic [TAPS-1:0]   w_cnt_inc;
    logic [TAPS-1:0]   w_tap_stb_nxt;
    logic [NUM_CH-1:0] w_pend;
    logic [NUM_CH-1:0] w_acc;
    logic              w_ready;

    // Tap i strobes when the low i+1 bits of the incremented count are all zero.
    always_comb begin : tap_decode
        logic v_zero;
        w_cnt_inc = r_cnt + TAPS'(1);
        v_zero    = 1'b1;
        for (int i = 0; i < TAPS; i++) begin
            v_zero           = v_zero & ~w_cnt_inc[i];
            w_tap_stb_nxt[i] = v_zero;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_tap_stb <= '0;
        end else if (en) begin
            r_cnt     <= w_cnt_inc;
            r_tap_stb <= w_tap_stb_nxt;
        end else begin
            r_tap_stb <= '0;
        end
    end

    assign tap_out = r_cnt;
    assign tap_stb = r_tap_stb;

    // Handshake: a write transfers on any cycle with cfg_valid && cfg_ready.
    // cfg_ready is low only while the addressed channel already holds a
    // pending ratio; out-of-range channels always accept and drop the write.
    always_comb begin
        w_ready = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (cfg_ch == CH_W'(c)) begin
                w_ready = ~w_pend[c];
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            w_acc[c] = cfg_valid & w_ready & (cfg_ch == CH_W'(c));
        end
    end

    assign cfg_ready = w_ready;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clock_div_channel #(
            .DIV_W(DIV_W)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .en       (en),
            .i_acc    (w_acc[g]),
            .i_acc_div(cfg_div),
            .o_pend   (w_pend[g]),
            .o_stb    (ch_stb[g]),
            .o_sq     (ch_sq[g])
        );
    end

endmodule
